uart_tx_fifo: RTL and testbench

Parametrised serial transmitter, successor to the fixed 8-bit `transmitter`. Accepts words through a valid/ready handshake into an internal FIFO and serialises them back-to-back onto `Tx`. Frame: start bit, `DATA_W` data bits LSB first, optional parity bit, 1 or 2 stop bits. Data width, bit period, parity mode, stop-bit count and buffer depth are all configurable. Sits on the same single-ended `Tx` line the existing `receiver` and differential buffers consume.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: parity modes, FSM state
// encoding and the parity helper used when a word is loaded.
package serial_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam int PARITY_MAX_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Callers zero-extend narrower words; the extra zero bits leave the XOR unchanged.
   function automatic logic parity_bit(input logic [PARITY_MAX_W-1:0] word,
                                       input int                      mode);
      return (mode == PAR_ODD) ? ~(^word) : ^word;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and a registered occupancy count;
// full/empty decode only from the occupancy register.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   level_q, level_d;
   logic             do_wr, do_rd;

   assign full  = (level_q == FULL_LEVEL);
   assign empty = (level_q == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + (PTR_W+1)'(1);
         2'b01:   level_d = level_q - (PTR_W+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words enter a FIFO via valid/ready and are
// serialised back-to-back as start, data (LSB first), optional parity, stop.
module uart_tx_fifo
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY       = 1,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          drop,
   output logic                          Tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   tx_state_t         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] shift_q;
   logic              par_q;
   logic              tx_q;
   logic              drop_q;

   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              bit_end, last_stop, pop;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tx_valid),
      .wr_data (tx_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign tx_ready  = !fifo_full;
   assign bit_end   = (cnt_q == LAST_CNT);
   assign last_stop = (state_q == ST_STOP) && bit_end && (idx_q == LAST_STOP);
   // A pop happens from idle or on the last stop cycle, so frames run back-to-back.
   assign pop       = !fifo_empty && ((state_q == ST_IDLE) || last_stop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else if (state_q == ST_IDLE) begin
         cnt_q <= '0;
         idx_q <= '0;
         if (pop) begin
            shift_q <= fifo_rd_data;
            par_q   <= parity_bit(PARITY_MAX_W'(fifo_rd_data), PARITY);
            tx_q    <= 1'b0;
            state_q <= ST_START;
         end
      end else if (!bit_end) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= '0;
         case (state_q)
            ST_START: begin
               tx_q    <= shift_q[0];
               shift_q <= shift_q >> 1;
               idx_q   <= '0;
               state_q <= ST_DATA;
            end
            ST_DATA: begin
               if (idx_q == LAST_IDX) begin
                  idx_q <= '0;
                  if (PARITY != PAR_NONE) begin
                     tx_q    <= par_q;
                     state_q <= ST_PARITY;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
            ST_PARITY: begin
               idx_q   <= '0;
               tx_q    <= 1'b1;
               state_q <= ST_STOP;
            end
            ST_STOP: begin
               if (idx_q == LAST_STOP) begin
                  idx_q <= '0;
                  if (pop) begin
                     shift_q <= fifo_rd_data;
                     par_q   <= parity_bit(PARITY_MAX_W'(fifo_rd_data), PARITY);
                     tx_q    <= 1'b0;
                     state_q <= ST_START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_q <= 1'b0;
      else        drop_q <= tx_valid && !tx_ready;
   end

   assign Tx   = tx_q;
   assign busy = (state_q != ST_IDLE);
   assign drop = drop_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a per-cycle vector table for the default
// configuration plus hand-written sequences for other configurations and reset.
module tb_uart_tx_fifo;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0] d0;  logic v0, rdy0, drop0, tx0, busy0;  logic [2:0] lvl0;
   logic [7:0] d1;  logic v1, rdy1, drop1, tx1, busy1;  logic [2:0] lvl1;
   logic [4:0] d2;  logic v2, rdy2, drop2, tx2, busy2;  logic [2:0] lvl2;

   uart_tx_fifo u0 (
      .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
      .drop(drop0), .Tx(tx0), .busy(busy0), .level(lvl0));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
      .drop(drop1), .Tx(tx1), .busy(busy1), .level(lvl1));

   uart_tx_fifo #(.DATA_W(5), .PARITY(0)) u2 (
      .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2), .tx_ready(rdy2),
      .drop(drop2), .Tx(tx2), .busy(busy2), .level(lvl2));

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       tx;
      logic       busy;
      logic [2:0] lvl;
      logic       rdy;
      logic       drp;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic void add(input logic v, input logic [7:0] d, input logic tx,
                               input logic b, input logic [2:0] l, input logic r,
                               input logic dr);
      vec_t e;
      e.v = v; e.d = d; e.tx = tx; e.busy = b; e.lvl = l; e.rdy = r; e.drp = dr;
      tbl.push_back(e);
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Waits (bounded) for a start bit on u0, then samples 8 data bits, parity and stop.
   task automatic recv0(output logic [7:0] w, output int gap, output logic p, output logic s);
      gap = 0;
      w   = '0;
      do begin
         step();
         gap++;
      end while (tx0 !== 1'b0 && gap < 40);
      for (int i = 0; i < 8; i++) begin
         step();
         w[i] = tx0;
      end
      step(); p = tx0;
      step(); s = tx0;
   endtask

   // Runs n cycles on u1 and counts cycles where Tx differs from val or busy is low.
   task automatic run1(input string nm, input logic val, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (tx1 !== val || busy1 !== 1'b1) bad++;
      end
      chk(nm, bad, 0);
   endtask

   initial begin
      logic [7:0] w;
      int         gap;
      logic       p, s;
      logic [7:0] exp_w   [4];
      logic       exp_par [4];
      logic [5:0] u2_bits;
      int         bad;

      rst_n = 1'b0;
      v0 = 1'b0; d0 = '0;
      v1 = 1'b0; d1 = '0;
      v2 = 1'b0; d2 = '0;

      repeat (2) step();
      chk("rst_tx",    tx0,   1);
      chk("rst_ready", rdy0,  1);
      chk("rst_drop",  drop0, 0);
      chk("rst_busy",  busy0, 0);
      chk("rst_level", lvl0,  0);
      chk("rst_u1_tx", {tx1, rdy1, drop1, busy1}, 4'b1100);
      chk("rst_u2_tx", {tx2, rdy2, drop2, busy2}, 4'b1100);
      rst_n = 1'b1;

      // Single word 0x43: start, 1,1,0,0,0,0,1,0, even parity 1, stop, idle.
      add(1, 8'h43, 1, 0, 1, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 1, 0, 0, 1, 0);
      // 0x43 then 0x4C on consecutive edges: 22 contiguous frame cycles.
      add(1, 8'h43, 1, 0, 1, 1, 0);
      add(1, 8'h4C, 0, 1, 1, 1, 0);
      add(0, 8'h00, 1, 1, 1, 1, 0);
      add(0, 8'h00, 1, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0);
      add(0, 8'h00, 1, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0);
      add(0, 8'h00, 1, 1, 1, 1, 0);
      add(0, 8'h00, 1, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 1, 1, 0, 1, 0);
      add(0, 8'h00, 1, 0, 0, 1, 0);
      // Six writes 1..6: FIFO fills, word 6 rejected with one drop pulse; frame of word 1.
      add(1, 8'h01, 1, 0, 1, 1, 0);
      add(1, 8'h02, 0, 1, 1, 1, 0);
      add(1, 8'h03, 1, 1, 2, 1, 0);
      add(1, 8'h04, 0, 1, 3, 1, 0);
      add(1, 8'h05, 0, 1, 4, 0, 0);
      add(1, 8'h06, 0, 1, 4, 0, 1);
      add(0, 8'hEE, 0, 1, 4, 0, 0);
      add(0, 8'h00, 0, 1, 4, 0, 0);
      add(0, 8'h00, 0, 1, 4, 0, 0);
      add(0, 8'h00, 0, 1, 4, 0, 0);
      add(0, 8'h00, 1, 1, 4, 0, 0);
      add(0, 8'h00, 1, 1, 4, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         v0 = tbl[i].v;
         d0 = tbl[i].d;
         step();
         chk($sformatf("row%0d_tx",    i), tx0,   tbl[i].tx);
         chk($sformatf("row%0d_busy",  i), busy0, tbl[i].busy);
         chk($sformatf("row%0d_level", i), lvl0,  tbl[i].lvl);
         chk($sformatf("row%0d_ready", i), rdy0,  tbl[i].rdy);
         chk($sformatf("row%0d_drop",  i), drop0, tbl[i].drp);
      end
      v0 = 1'b0;

      // Remaining queued words 2..5 follow with no idle gap; word 6 never appears.
      exp_w[0] = 8'h02; exp_par[0] = 1'b1;
      exp_w[1] = 8'h03; exp_par[1] = 1'b0;
      exp_w[2] = 8'h04; exp_par[2] = 1'b1;
      exp_w[3] = 8'h05; exp_par[3] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         recv0(w, gap, p, s);
         chk($sformatf("burst%0d_gap",  k), gap, 1);
         chk($sformatf("burst%0d_word", k), w,   exp_w[k]);
         chk($sformatf("burst%0d_par",  k), p,   exp_par[k]);
         chk($sformatf("burst%0d_stop", k), s,   1);
      end
      step();
      chk("burst_end_busy",  busy0, 0);
      chk("burst_end_level", lvl0,  0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
      chk("burst_no_sixth", bad, 0);

      // u1: 4 clocks/bit, odd parity, 2 stop bits, word 0x00 -> 48-cycle frame.
      v1 = 1'b1; d1 = 8'h00;
      step();
      v1 = 1'b0;
      chk("u1_accept_level", lvl1, 1);
      chk("u1_accept_tx",    tx1,  1);
      step();
      chk("u1_first_start", {tx1, busy1}, 2'b01);
      run1("u1_start_data", 1'b0, 35);
      run1("u1_odd_parity", 1'b1, 4);
      run1("u1_stop",       1'b1, 8);
      step();
      chk("u1_idle", {tx1, busy1}, 2'b10);

      // u2: 5 data bits, no parity, word 0x15.
      u2_bits = 6'b110101;
      v2 = 1'b1; d2 = 5'h15;
      step();
      v2 = 1'b0;
      step();
      chk("u2_start", tx2, 0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("u2_bit%0d", i), tx2, u2_bits[i]);
      end
      step();
      chk("u2_idle", {tx2, busy2}, 2'b10);

      // Reset in the 5th data cycle of 0xA5 with 0x5A and 0x3C still queued.
      v0 = 1'b1; d0 = 8'hA5;
      step();
      d0 = 8'h5A;
      step();
      d0 = 8'h3C;
      step();
      v0 = 1'b0;
      repeat (4) step();
      chk("pre_rst_tx",    tx0,  0);
      chk("pre_rst_level", lvl0, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx",    tx0,   1);
      chk("mid_rst_level", lvl0,  0);
      chk("mid_rst_busy",  busy0, 0);
      chk("mid_rst_ready", rdy0,  1);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || lvl0 !== 3'd0) bad++;
      end
      chk("post_rst_quiet", bad, 0);
      v0 = 1'b1; d0 = 8'h43;
      step();
      v0 = 1'b0;
      recv0(w, gap, p, s);
      chk("post_rst_gap",  gap, 1);
      chk("post_rst_word", w,   8'h43);
      chk("post_rst_par",  p,   1);
      chk("post_rst_stop", s,   1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
